pig_impact_gen: RTL and testbench
=================================

// Module: pig_impact_gen
// PURPOSE
//  Producer side of the pig force interface: watches the raster scan for overlap of the bird and pig
//  pixels, and uses pig_dir to work out which side of the pig was hit. Once per frame it converts the
//  bird velocity into a one-frame impulse on pig_force_x/pig_force_y. One instance per pig sits between
//  the bird object, the pig object and the VGA timing.
// PARAMETERS
//  FORCE_SHIFT  3        impulse magnitude = |bird_v| >>> FORCE_SHIFT
//  MIN_KICK     17'd32   minimum impulse magnitude (Q10.6, 0.5 px/frame) on each hit axis
//  MAX_FORCE    17'd1024 impulse magnitude clamp (16 px/frame)
//  MIN_OVERLAP  10'd4    overlapping pixels per frame needed to register a hit
//  COOL_FRAMES  4'd8     frames ignored after a hit (debounce)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous active-high reset
//  vsync        in   1   frame strobe, high for exactly one clk per frame
//  h_cnt        in   10  current pixel column
//  v_cnt        in   10  current pixel row
//  bird         in   1   bird pixel present at (h_cnt,v_cnt)
//  pig          in   1   pig pixel present at (h_cnt,v_cnt)
//  pig_dir      in   4   {nearX, nearY, h_cnt>x, v_cnt>y} relative to pig centre
//  bird_vx      in   17  bird x velocity, signed Q10.6
//  bird_vy      in   17  bird y velocity, signed Q10.6
//  pig_force_x  out  17  signed Q10.6 impulse, non-zero for exactly one frame per hit
//  pig_force_y  out  17  signed Q10.6 impulse
//  hit          out  1   one-clk pulse in the cycle after the vsync that registers a hit
//  hit_count    out  8   saturating hit total since reset
// BEHAVIOUR
//  Reset: state=SCAN, all counters 0, pig_force_x/y=0, hit=0, hit_count=0, cool_cnt=0.
//  Pixel qualify: sample a pixel only when {h_cnt,v_cnt} differs from the value registered on the previous clk.
//    Each pixel is counted once, regardless of the clk/pixel clock ratio.
//  Overlap: for each qualified pixel with bird&pig, ovl_cnt += 1 (10b, saturates at 1023).
//    Side counters are 8b and saturate at 255:
//      pig_dir[1]=0 -> cnt_l++, else cnt_r++
//      pig_dir[0]=0 -> cnt_t++, else cnt_b++
//  States, transitions only on vsync:
//    SCAN: if ovl_cnt>=MIN_OVERLAP, compute the impulse -> APPLY, pulse hit, hit_count++ (saturates at 255).
//          Otherwise stay in SCAN. Outputs stay 0.
//    APPLY: outputs hold the impulse. On the next vsync, force 0 the following clk and go to COOLDOWN
//          with cool_cnt=COOL_FRAMES.
//    COOLDOWN: overlaps are ignored. cool_cnt-- on each vsync; at 0 go to SCAN.
//          With COOL_FRAMES=0, APPLY goes directly to SCAN.
//  All overlap and side counters clear on every vsync, in every state (same clk as the decision).
//  Impulse, computed from the values registered at vsync:
//    mag_x = clamp(max(|bird_vx|>>>FORCE_SHIFT, MIN_KICK), MAX_FORCE)
//    |-65536| saturates to 65535 before the shift.
//    Sign: cnt_l>cnt_r -> +mag_x; cnt_r>cnt_l -> -mag_x.
//    If cnt_l==cnt_r: nearX side (pig_dir[3] majority) gives 0; otherwise sign(bird_vx), with 0 -> +.
//    Y uses the same rule with t/b: cnt_t>cnt_b pushes down (+).
//    Both axes 0 -> still APPLY, with the x impulse forced to +MIN_KICK so the pig latches the hit.
//  Timing contract: force is visible from clk vsync_N+1 through vsync_N+1 inclusive.
//    The pig consumes it at the vsync_N+1 edge, so exactly one application per hit.
//  Simultaneous events: vsync on a qualified overlap pixel -> the decision excludes that pixel, and it
//    is counted into the new frame.
//  rst in any state: immediate return to reset values on the next clk; any pending impulse is dropped.
// TESTING
//  1. Reset, no overlap for 3 vsyncs -> force 0, hit never asserted, hit_count=0.
//  2. 6 overlap px, all pig_dir[1]=0, pig_dir[0]=1, bird_vx=+640, bird_vy=-64.
//     Then vsync -> force_x=+80, force_y=-32; hit pulse; next vsync +1 clk -> force 0.
//  3. bird_vx=+16000, left hit -> force_x clamped to +1024.
//     bird_vx=-65536, right hit -> force_x=-1024.
//  4. 3 overlap px only (<MIN_OVERLAP), then vsync -> no hit. Next frame 4 px -> hit.
//  5. Hit, then overlap each frame for 10 frames -> exactly two hits, 10 vsyncs apart (1 APPLY + 8 cooldown + 1).
//  6. Each pixel held 4 clks: 4 px counted as 4, not 16. Assert rst during APPLY -> force 0 the next clk, state SCAN.

Source files
------------

// File: rtl/pig_impact_gen_if.sv
// Pig force interface: raster/bird/pig inputs in, one-frame impulse and hit strobe out.
// vsync is a single-clk frame strobe; hit is a single-clk pulse the clk after a hit-registering vsync.
interface pig_impact_gen_if;
  logic               vsync;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic               bird;
  logic               pig;
  logic [3:0]         pig_dir;
  logic signed [16:0] bird_vx;
  logic signed [16:0] bird_vy;
  logic signed [16:0] pig_force_x;
  logic signed [16:0] pig_force_y;
  logic               hit;
  logic [7:0]         hit_count;
  // FSM state for observation: 0=SCAN, 1=APPLY, 2=COOLDOWN
  logic [1:0]         dbg_state;

  modport master (
    output vsync, h_cnt, v_cnt, bird, pig, pig_dir, bird_vx, bird_vy,
    input  pig_force_x, pig_force_y, hit, hit_count, dbg_state
  );

  modport slave (
    input  vsync, h_cnt, v_cnt, bird, pig, pig_dir, bird_vx, bird_vy,
    output pig_force_x, pig_force_y, hit, hit_count, dbg_state
  );
endinterface

// File: rtl/pig_impact_gen.sv
// Counts bird/pig pixel overlap per frame, decides the hit side and issues a one-frame
// velocity-derived impulse to the pig, followed by a debounce cooldown.
module pig_impact_gen #(
  parameter int unsigned FORCE_SHIFT = 3,
  parameter logic [16:0] MIN_KICK    = 17'd32,
  parameter logic [16:0] MAX_FORCE   = 17'd1024,
  parameter logic [9:0]  MIN_OVERLAP = 10'd4,
  parameter logic [3:0]  COOL_FRAMES = 4'd8
) (
  input  logic             clk,
  input  logic             rst,
  pig_impact_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_SCAN  = 2'd0,
    S_APPLY = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  localparam logic [1:0] D_ZERO  = 2'd0;
  localparam logic [1:0] D_PLUS  = 2'd1;
  localparam logic [1:0] D_MINUS = 2'd2;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cool, w_cool_nxt;
  logic signed [16:0] r_fx, r_fy, w_fx_nxt, w_fy_nxt;
  logic               r_hit, w_hit_nxt;
  logic [7:0]         r_hcnt, w_hcnt_nxt;

  logic [19:0] r_pos;
  logic        r_pos_vld;
  logic [9:0]  r_ovl, r_nx, r_ny;
  logic [7:0]  r_l, r_r, r_t, r_b;
  logic        w_new_px, w_ovl, w_near_x, w_near_y;
  logic [16:0] w_mag_x, w_mag_y;
  logic [1:0]  w_dir_x, w_dir_y;
  logic signed [16:0] w_imp_x, w_imp_y;

  function automatic logic [9:0] inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // |v| with -65536 saturated to 65535, scaled, then floored at MIN_KICK and clamped at MAX_FORCE
  function automatic logic [16:0] mag_of(input logic signed [16:0] v);
    logic [16:0] a;
    logic [16:0] s;
    if (v[16] && (v[15:0] == 16'd0)) a = 17'h0FFFF;
    else if (v[16])                  a = $unsigned(-v);
    else                             a = $unsigned(v);
    s = a >> FORCE_SHIFT;
    if (s < MIN_KICK)  s = MIN_KICK;
    if (s > MAX_FORCE) s = MAX_FORCE;
    return s;
  endfunction

  function automatic logic [1:0] side_of(input logic [7:0] a, input logic [7:0] b,
                                         input logic near, input logic neg);
    if (a > b)     return D_PLUS;
    if (b > a)     return D_MINUS;
    if (near)      return D_ZERO;
    return neg ? D_MINUS : D_PLUS;
  endfunction

  function automatic logic signed [16:0] signed_mag(input logic [16:0] m, input logic [1:0] d);
    case (d)
      D_PLUS:  return $signed(m);
      D_MINUS: return $signed(~m + 17'd1);
      default: return 17'sd0;
    endcase
  endfunction

  // A pixel counts once, on the first clk its coordinates appear
  assign w_new_px = !r_pos_vld || ({bus.h_cnt, bus.v_cnt} != r_pos);
  assign w_ovl    = w_new_px && bus.bird && bus.pig && (r_state != S_COOL);
  assign w_near_x = {r_nx, 1'b0} > {1'b0, r_ovl};
  assign w_near_y = {r_ny, 1'b0} > {1'b0, r_ovl};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos     <= '0;
      r_pos_vld <= 1'b0;
      r_ovl     <= '0;
      r_nx      <= '0;
      r_ny      <= '0;
      r_l       <= '0;
      r_r       <= '0;
      r_t       <= '0;
      r_b       <= '0;
    end else begin
      r_pos     <= {bus.h_cnt, bus.v_cnt};
      r_pos_vld <= 1'b1;
      // A pixel coincident with vsync seeds the new frame rather than the closing one
      if (bus.vsync) begin
        r_ovl <= {9'd0, w_ovl};
        r_nx  <= {9'd0, w_ovl && bus.pig_dir[3]};
        r_ny  <= {9'd0, w_ovl && bus.pig_dir[2]};
        r_l   <= {7'd0, w_ovl && !bus.pig_dir[1]};
        r_r   <= {7'd0, w_ovl && bus.pig_dir[1]};
        r_t   <= {7'd0, w_ovl && !bus.pig_dir[0]};
        r_b   <= {7'd0, w_ovl && bus.pig_dir[0]};
      end else if (w_ovl) begin
        r_ovl <= inc10(r_ovl);
        if (bus.pig_dir[3]) r_nx <= inc10(r_nx);
        if (bus.pig_dir[2]) r_ny <= inc10(r_ny);
        if (bus.pig_dir[1]) r_r <= inc8(r_r);
        else                r_l <= inc8(r_l);
        if (bus.pig_dir[0]) r_b <= inc8(r_b);
        else                r_t <= inc8(r_t);
      end
    end
  end

  always_comb begin
    w_mag_x = mag_of(bus.bird_vx);
    w_mag_y = mag_of(bus.bird_vy);
    w_dir_x = side_of(r_l, r_r, w_near_x, bus.bird_vx[16]);
    w_dir_y = side_of(r_t, r_b, w_near_y, bus.bird_vy[16]);
    w_imp_x = signed_mag(w_mag_x, w_dir_x);
    w_imp_y = signed_mag(w_mag_y, w_dir_y);
    // The pig only latches a hit on a non-zero impulse, so never send all zeros
    if ((w_dir_x == D_ZERO) && (w_dir_y == D_ZERO)) w_imp_x = $signed(MIN_KICK);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cool_nxt  = r_cool;
    w_fx_nxt    = r_fx;
    w_fy_nxt    = r_fy;
    w_hit_nxt   = 1'b0;
    w_hcnt_nxt  = r_hcnt;
    if (bus.vsync) begin
      case (r_state)
        S_SCAN: begin
          if (r_ovl >= MIN_OVERLAP) begin
            w_state_nxt = S_APPLY;
            w_fx_nxt    = w_imp_x;
            w_fy_nxt    = w_imp_y;
            w_hit_nxt   = 1'b1;
            w_hcnt_nxt  = inc8(r_hcnt);
          end
        end
        S_APPLY: begin
          w_fx_nxt = 17'sd0;
          w_fy_nxt = 17'sd0;
          if (COOL_FRAMES == 4'd0) begin
            w_state_nxt = S_SCAN;
          end else begin
            w_state_nxt = S_COOL;
            w_cool_nxt  = COOL_FRAMES;
          end
        end
        S_COOL: begin
          w_cool_nxt = (r_cool == 4'd0) ? 4'd0 : r_cool - 4'd1;
          if (r_cool <= 4'd1) w_state_nxt = S_SCAN;
        end
        default: w_state_nxt = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SCAN;
      r_cool  <= '0;
      r_fx    <= '0;
      r_fy    <= '0;
      r_hit   <= 1'b0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cool  <= w_cool_nxt;
      r_fx    <= w_fx_nxt;
      r_fy    <= w_fy_nxt;
      r_hit   <= w_hit_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  assign bus.pig_force_x = r_fx;
  assign bus.pig_force_y = r_fy;
  assign bus.hit         = r_hit;
  assign bus.hit_count   = r_hcnt;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_pig_impact_gen.sv
// Bench for pig_impact_gen: directed scenarios plus randomized frames checked against a
// frame-level reference model through an expected-hit queue.
`timescale 1ns/1ps
module tb_pig_impact_gen;

  localparam int HIT_SPACING = 2 + 8;  // APPLY frame + cooldown frames + one scanning frame

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pig_impact_gen_if bus();

  pig_impact_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int hit_seen = 0;
  logic [41:0] exp_q[$];

  // Reference model state: per-frame overlap tallies and hit history by vsync index
  int fr_n, fr_l, fr_r, fr_t, fr_b, fr_nx, fr_ny;
  int vs_idx = 0;
  int last_hit = -100;
  int hit_total = 0;
  int cur_vx = 0;
  int cur_vy = 0;
  int px_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int mag_of(input int v);
    int a;
    a = (v < 0) ? -v : v;
    if (a > 65535) a = 65535;
    a = a / 8;
    if (a < 32) a = 32;
    if (a > 1024) a = 1024;
    return a;
  endfunction

  function automatic int side_of(input int a, input int b, input bit near, input int v);
    if (a > b) return 1;
    if (b > a) return -1;
    if (near) return 0;
    return (v < 0) ? -1 : 1;
  endfunction

  function automatic void frame_clear();
    fr_n = 0; fr_l = 0; fr_r = 0; fr_t = 0; fr_b = 0; fr_nx = 0; fr_ny = 0;
  endfunction

  function automatic void frame_add(input logic [3:0] d);
    fr_n++;
    if (d[1]) fr_r++; else fr_l++;
    if (d[0]) fr_b++; else fr_t++;
    if (d[3]) fr_nx++;
    if (d[2]) fr_ny++;
  endfunction

  function automatic void model_reset();
    frame_clear();
    last_hit = -100;
    hit_total = 0;
    exp_q.delete();
  endfunction

  function automatic void model_vsync();
    int dx, dy, fx, fy;
    vs_idx++;
    if (fr_n >= 4 && (vs_idx - last_hit) >= HIT_SPACING) begin
      dx = side_of(fr_l, fr_r, (2 * fr_nx) > fr_n, cur_vx);
      dy = side_of(fr_t, fr_b, (2 * fr_ny) > fr_n, cur_vy);
      fx = dx * mag_of(cur_vx);
      fy = dy * mag_of(cur_vy);
      if (dx == 0 && dy == 0) fx = 32;
      if (hit_total < 255) hit_total++;
      last_hit = vs_idx;
      exp_q.push_back({17'(fx), 17'(fy), 8'(hit_total)});
    end
    frame_clear();
  endfunction

  task automatic set_vel(input int vx, input int vy);
    cur_vx = vx;
    cur_vy = vy;
    bus.bird_vx = 17'(vx);
    bus.bird_vy = 17'(vy);
  endtask

  task automatic next_pos();
    px_idx = (px_idx + 1) % 300000;
    bus.h_cnt = 10'(px_idx % 640);
    bus.v_cnt = 10'(px_idx / 640);
  endtask

  task automatic drive_px(input logic b, input logic p, input logic [3:0] d, input int hold);
    @(negedge clk);
    bus.vsync = 1'b0;
    next_pos();
    bus.bird = b;
    bus.pig = p;
    bus.pig_dir = d;
    repeat (hold - 1) @(negedge clk);
    if (b && p) frame_add(d);
  endtask

  task automatic do_vsync(input logic ovl, input logic [3:0] d);
    @(negedge clk);
    bus.vsync = 1'b1;
    next_pos();
    bus.bird = ovl;
    bus.pig = ovl;
    bus.pig_dir = d;
    model_vsync();
    if (ovl) frame_add(d);
    @(negedge clk);
    bus.vsync = 1'b0;
    next_pos();
    bus.bird = 1'b0;
    bus.pig = 1'b0;
  endtask

  task automatic ovl_px(input int n, input logic [3:0] d, input int hold);
    for (int i = 0; i < n; i++) begin
      drive_px(1'b1, 1'b1, d, hold);
      drive_px(1'b0, 1'b1, d, 1);
    end
  endtask

  task automatic idle_frames(input int n);
    repeat (n) begin
      drive_px(1'b1, 1'b0, 4'd0, 1);
      drive_px(1'b0, 1'b0, 4'd0, 2);
      do_vsync(1'b0, 4'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: every hit pulse must match the next model-predicted impulse
  always @(negedge clk) begin
    if (!rst && bus.hit) begin
      logic [41:0] e;
      hit_seen++;
      chk("hit_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_force_x", int'(bus.pig_force_x), int'($signed(e[41:25])));
        chk("mon_force_y", int'(bus.pig_force_y), int'($signed(e[24:8])));
        chk("mon_hit_count", int'(bus.hit_count), int'(e[7:0]));
      end
    end
  end

  initial begin
    int hb, first_f, second_f, n, vsel;
    logic [3:0] d;

    rst = 1'b1;
    bus.vsync = 1'b0;
    bus.h_cnt = '0;
    bus.v_cnt = '0;
    bus.bird = 1'b0;
    bus.pig = 1'b0;
    bus.pig_dir = '0;
    set_vel(0, 0);
    frame_clear();
    do_reset();

    // Reset state and idle frames
    chk("rst_force_x", int'(bus.pig_force_x), 0);
    chk("rst_force_y", int'(bus.pig_force_y), 0);
    chk("rst_hit", int'(bus.hit), 0);
    chk("rst_hit_count", int'(bus.hit_count), 0);
    chk("rst_state", int'(bus.dbg_state), 0);
    idle_frames(3);
    chk("idle_hit_seen", hit_seen, 0);
    chk("idle_force_x", int'(bus.pig_force_x), 0);
    chk("idle_hit_count", int'(bus.hit_count), 0);

    // Basic left/bottom hit and one-frame impulse window
    set_vel(640, -64);
    ovl_px(6, 4'b0001, 1);
    do_vsync(1'b0, 4'd0);
    chk("basic_force_x", int'(bus.pig_force_x), 80);
    chk("basic_force_y", int'(bus.pig_force_y), -32);
    chk("basic_hit", int'(bus.hit), 1);
    chk("basic_hit_count", int'(bus.hit_count), 1);
    chk("basic_state_apply", int'(bus.dbg_state), 1);
    drive_px(1'b0, 1'b0, 4'd0, 3);
    chk("basic_hit_pulse_width", int'(bus.hit), 0);
    chk("basic_force_held", int'(bus.pig_force_x), 80);
    do_vsync(1'b0, 4'd0);
    chk("basic_force_x_clear", int'(bus.pig_force_x), 0);
    chk("basic_force_y_clear", int'(bus.pig_force_y), 0);
    chk("basic_state_cool", int'(bus.dbg_state), 2);
    idle_frames(9);

    // Clamping
    set_vel(16000, 0);
    ovl_px(5, 4'b0000, 1);
    do_vsync(1'b0, 4'd0);
    chk("clamp_pos_x", int'(bus.pig_force_x), 1024);
    idle_frames(10);
    set_vel(-65536, 0);
    ovl_px(5, 4'b0010, 1);
    do_vsync(1'b0, 4'd0);
    chk("clamp_neg_x", int'(bus.pig_force_x), -1024);
    idle_frames(10);

    // Overlap threshold
    set_vel(640, 640);
    ovl_px(3, 4'b0100, 1);
    do_vsync(1'b0, 4'd0);
    chk("thresh_3_hit", int'(bus.hit), 0);
    chk("thresh_3_count", int'(bus.hit_count), 3);
    ovl_px(4, 4'b0100, 1);
    do_vsync(1'b0, 4'd0);
    chk("thresh_4_hit", int'(bus.hit), 1);
    chk("thresh_4_count", int'(bus.hit_count), 4);
    idle_frames(10);

    // Debounce: continuous overlap gives hits 10 vsyncs apart
    hb = hit_seen;
    first_f = -1;
    second_f = -1;
    for (int f = 0; f <= 10; f++) begin
      ovl_px(5, 4'($urandom_range(0, 15)), 1);
      do_vsync(1'b0, 4'd0);
      if (bus.hit) begin
        if (first_f < 0) first_f = f;
        else second_f = f;
      end
    end
    idle_frames(9);
    chk("debounce_hits", hit_seen - hb, 2);
    chk("debounce_spacing", second_f - first_f, 10);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      vsel = $urandom_range(0, 5);
      case (vsel)
        0: set_vel(-65536, 65535);
        1: set_vel(0, 0);
        default: set_vel(int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 40000)) - 20000);
      endcase
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        d = 4'($urandom_range(0, 15));
        drive_px(1'b1, 1'b1, d, $urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) drive_px(1'($urandom_range(0, 1)), 1'b0, d, 1);
      end
      do_vsync(1'b0, 4'd0);
    end
    idle_frames(9);

    // Overlap pixel coincident with vsync belongs to the new frame
    set_vel(300, -300);
    ovl_px(3, 4'b0000, 1);
    do_vsync(1'b1, 4'b0000);
    chk("simul_no_hit", int'(bus.hit), 0);
    ovl_px(3, 4'b0000, 1);
    do_vsync(1'b0, 4'd0);
    chk("simul_carry_hit", int'(bus.hit), 1);
    idle_frames(9);

    // Held pixels count once; reset during APPLY
    ovl_px(3, 4'b1000, 4);
    do_vsync(1'b0, 4'd0);
    chk("hold_3px_no_hit", int'(bus.hit), 0);
    ovl_px(4, 4'b1000, 4);
    do_vsync(1'b0, 4'd0);
    chk("hold_4px_hit", int'(bus.hit), 1);
    @(negedge clk);
    chk("pre_rst_state_apply", int'(bus.dbg_state), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_apply_force_x", int'(bus.pig_force_x), 0);
    chk("rst_apply_force_y", int'(bus.pig_force_y), 0);
    chk("rst_apply_state", int'(bus.dbg_state), 0);
    chk("rst_apply_hit_count", int'(bus.hit_count), 0);
    rst = 1'b0;
    model_reset();
    set_vel(-640, 0);
    ovl_px(5, 4'b0011, 1);
    do_vsync(1'b0, 4'd0);
    chk("post_rst_hit_count", int'(bus.hit_count), 1);
    chk("post_rst_force_x", int'(bus.pig_force_x), -80);
    idle_frames(2);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
